// File: rtl/uart_receiver.sv
// 8N1 LSB-first serial receiver with a two-flop input synchroniser, mid-bit sampling
// and a baud divider that is captured from cfg_divider at the start of every frame.
module uart_receiver (
   input  logic        clk_25mhz_unused_guard_n = 1'b1,
   input  logic        clk,
   input  logic        reset,
   input  logic        ser_rx,
   input  logic [31:0] cfg_divider,
   output logic [7:0]  data,
   output logic        valid,
   output logic        framing_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t      state, state_nxt;
   logic        rx_meta, rx_s;
   logic [31:0] div, half, cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;

   logic        half_hit, bit_hit;
   logic        latch_div, cnt_clr, start_ok, shift_en, load_byte, stop_bad;

   assign half     = div >> 1;
   // The counter is cleared on the edge that opens an interval, so the sampling
   // edge k cycles later is the one where the counter still reads k-1.
   assign half_hit = (cnt == half - 32'd1);
   assign bit_hit  = (cnt == div - 32'd1);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so no path leaves state_nxt unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (!rx_s) state_nxt = S_START;
         S_START: if (half_hit) state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:  if (bit_hit && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:  if (bit_hit) state_nxt = rx_s ? S_IDLE : S_BREAK;
         S_BREAK: if (rx_s) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      latch_div = 1'b0;
      start_ok  = 1'b0;
      shift_en  = 1'b0;
      load_byte = 1'b0;
      stop_bad  = 1'b0;
      cnt_clr   = 1'b0;
      unique case (state)
         S_IDLE: begin
            latch_div = !rx_s;
            cnt_clr   = 1'b1;
         end
         S_START: begin
            start_ok = half_hit && !rx_s;
            cnt_clr  = half_hit;
         end
         S_DATA: begin
            shift_en = bit_hit;
            cnt_clr  = bit_hit;
         end
         S_STOP: begin
            load_byte = bit_hit && rx_s;
            stop_bad  = bit_hit && !rx_s;
            cnt_clr   = bit_hit;
         end
         S_BREAK: cnt_clr = 1'b1;
         default: cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta       <= 1'b1;
         rx_s          <= 1'b1;
         div           <= 32'd0;
         cnt           <= 32'd0;
         bit_idx       <= 3'd0;
         shreg         <= 8'h00;
         data          <= 8'h00;
         valid         <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         rx_meta <= ser_rx;
         rx_s    <= rx_meta;
         if (latch_div)
            div <= cfg_divider;
         cnt <= cnt_clr ? 32'd0 : cnt + 32'd1;
         if (start_ok)
            bit_idx <= 3'd0;
         if (shift_en) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
         end
         if (load_byte)
            data <= shreg;
         valid         <= load_byte;
         framing_error <= stop_bad;
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised and directed bench for uart_receiver: a serial line driver plus a
// byte-level reference (list of expected bytes and error count) checked against a monitor.
module tb_uart_receiver;

   logic        clk = 1'b0;
   logic        reset;
   logic        ser_rx;
   logic [31:0] cfg_divider;
   logic [7:0]  data;
   logic        valid;
   logic        framing_error;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;

   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int          fe_cnt = 0;
   int          exp_fe = 0;
   logic [7:0]  exp_last = 8'h00;
   int unsigned last_valid_cyc = 0;
   logic        prev_pulse = 1'b0;

   uart_receiver dut (
      .clk           (clk),
      .reset         (reset),
      .ser_rx        (ser_rx),
      .cfg_divider   (cfg_divider),
      .data          (data),
      .valid         (valid),
      .framing_error (framing_error)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: collect decoded bytes and error pulses; pulses must be single-cycle and exclusive.
   always @(negedge clk) begin
      if (valid) begin
         rx_q.push_back(data);
         last_valid_cyc = cyc;
      end
      if (framing_error)
         fe_cnt++;
      if (valid || framing_error) begin
         check("pulse_exclusive", {31'd0, valid & framing_error}, 32'd0);
         check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      end
      prev_pulse = valid | framing_error;
   end

   task automatic line_bits(input logic v, input int n);
      ser_rx = v;
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame at bc clocks per bit; optionally disturb cfg_divider mid-frame.
   task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_v, input bit scramble);
      logic [31:0] keep;
      keep = cfg_divider;
      line_bits(1'b0, bc);
      if (scramble)
         cfg_divider = $urandom_range(1000, 4);
      for (int i = 0; i < 8; i++)
         line_bits(b[i], bc);
      line_bits(stop_v, bc);
      cfg_divider = keep;
   endtask

   task automatic good_byte(input logic [7:0] b, input int bc, input bit scramble);
      send_byte(b, bc, 1'b1, scramble);
      exp_q.push_back(b);
      exp_last = b;
   endtask

   task automatic expect_rx(input string tag);
      int n;
      check({tag, "_count"}, rx_q.size(), exp_q.size());
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check({tag, "_byte"}, rx_q[i], exp_q[i]);
      check({tag, "_ferr"}, fe_cnt, exp_fe);
      check({tag, "_data_hold"}, data, exp_last);
      rx_q.delete();
      exp_q.delete();
      fe_cnt = 0;
      exp_fe = 0;
   endtask

   initial begin
      #50ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned fall_cyc, d;
      int          bc;
      logic [7:0]  b;

      reset       = 1'b1;
      ser_rx      = 1'b1;
      cfg_divider = 32'd217;
      repeat (3) @(negedge clk);
      check("reset_data", data, 8'h00);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_ferr", {31'd0, framing_error}, 32'd0);
      reset = 1'b0;
      line_bits(1'b1, 20);

      // Single byte with timing of the valid pulse relative to the line's falling edge.
      fall_cyc = cyc;
      good_byte(8'h41, 217, 1'b0);
      line_bits(1'b1, 434);
      d = last_valid_cyc - fall_cyc;
      check("valid_timing", {31'd0, (d >= 108 + 9 * 217 + 2) && (d <= 108 + 9 * 217 + 4)}, 32'd1);
      expect_rx("byte_41");

      // Back-to-back frames with no idle gap.
      good_byte(8'h0D, 217, 1'b0);
      good_byte(8'h0A, 217, 1'b0);
      line_bits(1'b1, 434);
      expect_rx("b2b");

      // Short low glitch is rejected at the start check.
      line_bits(1'b0, 50);
      line_bits(1'b1, 400);
      expect_rx("glitch");
      good_byte(8'h7E, 217, 1'b0);
      line_bits(1'b1, 434);
      expect_rx("after_glitch");

      // Low stop bit followed by a held-low line: exactly one error.
      send_byte(8'h55, 217, 1'b0, 1'b0);
      line_bits(1'b0, 3 * 217);
      exp_fe = 1;
      line_bits(1'b1, 300);
      expect_rx("break");
      good_byte(8'h33, 217, 1'b0);
      line_bits(1'b1, 434);
      expect_rx("after_break");

      // Reset during data bit 4; the high tail of the frame must not decode.
      fork
         send_byte(8'hF0, 217, 1'b1, 1'b0);
         begin
            repeat (5 * 217 + 108) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check("midreset_data", data, 8'h00);
            check("midreset_valid", {31'd0, valid}, 32'd0);
            check("midreset_ferr", {31'd0, framing_error}, 32'd0);
            reset = 1'b0;
         end
      join
      exp_last = 8'h00;
      line_bits(1'b1, 434);
      expect_rx("midreset");
      good_byte(8'hA5, 217, 1'b0);
      line_bits(1'b1, 434);
      expect_rx("after_reset");

      // Minimum divider, back-to-back.
      cfg_divider = 32'd4;
      good_byte(8'hFF, 4, 1'b0);
      good_byte(8'h00, 4, 1'b0);
      line_bits(1'b1, 20);
      expect_rx("div4");

      // Baud mismatch of about 3% in both directions.
      cfg_divider = 32'd100;
      good_byte(8'hC3, 103, 1'b0);
      line_bits(1'b1, 100);
      good_byte(8'h3C, 97, 1'b0);
      line_bits(1'b1, 200);
      expect_rx("tolerance");

      // Random frames: random divider, byte, gap, mid-frame cfg changes and bad stops.
      for (int k = 0; k < 30; k++) begin
         bc          = $urandom_range(40, 4);
         cfg_divider = bc;
         b           = 8'($urandom);
         if ($urandom_range(5, 0) == 0) begin
            send_byte(b, bc, 1'b0, 1'($urandom));
            exp_fe++;
            line_bits(1'b0, $urandom_range(2 * bc, 0));
            line_bits(1'b1, bc);
         end else begin
            good_byte(b, bc, 1'($urandom));
            line_bits(1'b1, $urandom_range(2 * bc, 0));
         end
      end
      line_bits(1'b1, 100);
      expect_rx("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
